// File: rtl/fpu_ss_in_buf.sv
// ============================================================================
// fpu_ss_in_buf : FPU subsystem input buffer between issue acceptance and the
//                 controller (circular FIFO, optional fall-through/pass-through)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fpu_ss_in_buf #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic                                        push_valid_i,
  output logic                                        push_ready_o,
  input  logic [DATA_WIDTH-1:0]                       push_data_i,
  output logic                                        pop_valid_o,
  input  logic                                        pop_ready_i,
  output logic [DATA_WIDTH-1:0]                       pop_data_o,
  output logic [(DEPTH == 0 ? 1 : $clog2(DEPTH+1))-1:0] usage_o,
  output logic                                        full_o,
  output logic                                        empty_o
);

  localparam int unsigned CNT_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1);

  generate
    if (DEPTH == 0) begin : g_pass
      // Stateless: clock and reset are intentionally not consumed.
      logic w_unused;
      assign w_unused     = clk_i ^ rst_i;
      assign pop_valid_o  = push_valid_i & ~flush_i;
      assign push_ready_o = pop_ready_i & ~flush_i;
      assign pop_data_o   = push_data_i;
      assign usage_o      = '0;
      assign full_o       = 1'b0;
      assign empty_o      = 1'b1;
    end else begin : g_buf
      localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);
      localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0]      r_wr_ptr;
      logic [PTR_W-1:0]      r_rd_ptr;
      logic [CNT_W-1:0]      r_cnt;
      logic                  w_empty;
      logic                  w_full;
      logic                  w_bypass;
      logic                  w_push;
      logic                  w_pop;
      logic                  w_write;
      logic                  w_read;

      assign w_empty  = (r_cnt == '0);
      assign w_full   = (r_cnt == c_full);
      assign w_bypass = FALL_THROUGH & w_empty;

      // Ready is independent of pop_ready_i: no ready path through the buffer.
      assign push_ready_o = ~w_full & ~flush_i;
      assign pop_valid_o  = w_bypass ? (push_valid_i & ~flush_i) : (~w_empty & ~flush_i);
      assign pop_data_o   = w_bypass ? push_data_i : r_mem[r_rd_ptr];

      assign w_push  = push_valid_i & push_ready_o;
      assign w_pop   = pop_valid_o & pop_ready_i;
      // A pop while empty can only be a fall-through: it consumes the push directly.
      assign w_read  = w_pop & ~w_empty;
      assign w_write = w_push & ~(w_empty & w_pop);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end else if (flush_i) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else begin
          if (w_write) begin
            r_mem[r_wr_ptr] <= push_data_i;
            r_wr_ptr        <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
          end
          if (w_read) begin
            r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
          end
          if (w_write && !w_read) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_write && w_read) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end

      assign usage_o = r_cnt;
      assign full_o  = w_full;
      assign empty_o = w_empty;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_in_buf.sv
// Bench for fpu_ss_in_buf: three buffered configurations checked against queue
// models, plus a pass-through instance; directed scenarios then random traffic.
`default_nettype none

module tb_fpu_ss_in_buf;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Index 0: DEPTH=2, 1: DEPTH=3, 2: DEPTH=2 with fall-through
  logic [2:0]         pv, pr, fl;
  logic [2:0][DW-1:0] pd;
  logic [2:0]         prdy, vld, fullo, emptyo;
  logic [2:0][DW-1:0] dat;
  logic [2:0][1:0]    use_o;

  logic          p_pv, p_pr, p_fl, p_rdy, p_vld, p_use, p_full, p_empty;
  logic [DW-1:0] p_pd, p_dat;

  int checks = 0;
  int errors = 0;
  int dep[3] = '{2, 3, 2};
  bit ft[3]  = '{1'b0, 1'b0, 1'b1};
  logic [DW-1:0] mq [3][$];

  fpu_ss_in_buf #(.DATA_WIDTH(DW), .DEPTH(2), .FALL_THROUGH(1'b0)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl[0]),
    .push_valid_i(pv[0]), .push_ready_o(prdy[0]), .push_data_i(pd[0]),
    .pop_valid_o(vld[0]), .pop_ready_i(pr[0]), .pop_data_o(dat[0]),
    .usage_o(use_o[0]), .full_o(fullo[0]), .empty_o(emptyo[0]));

  fpu_ss_in_buf #(.DATA_WIDTH(DW), .DEPTH(3), .FALL_THROUGH(1'b0)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl[1]),
    .push_valid_i(pv[1]), .push_ready_o(prdy[1]), .push_data_i(pd[1]),
    .pop_valid_o(vld[1]), .pop_ready_i(pr[1]), .pop_data_o(dat[1]),
    .usage_o(use_o[1]), .full_o(fullo[1]), .empty_o(emptyo[1]));

  fpu_ss_in_buf #(.DATA_WIDTH(DW), .DEPTH(2), .FALL_THROUGH(1'b1)) u_f2 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl[2]),
    .push_valid_i(pv[2]), .push_ready_o(prdy[2]), .push_data_i(pd[2]),
    .pop_valid_o(vld[2]), .pop_ready_i(pr[2]), .pop_data_o(dat[2]),
    .usage_o(use_o[2]), .full_o(fullo[2]), .empty_o(emptyo[2]));

  fpu_ss_in_buf #(.DATA_WIDTH(DW), .DEPTH(0), .FALL_THROUGH(1'b0)) u_p0 (
    .clk_i(clk), .rst_i(rst), .flush_i(p_fl),
    .push_valid_i(p_pv), .push_ready_o(p_rdy), .push_data_i(p_pd),
    .pop_valid_o(p_vld), .pop_ready_i(p_pr), .pop_data_o(p_dat),
    .usage_o(p_use), .full_o(p_full), .empty_o(p_empty));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one buffer against its queue model, then advance the model by one edge.
  task automatic check_buf(input int k);
    int n;
    bit e_empty, e_full, e_rdy, e_vld, bypass, push, pop;
    logic [DW-1:0] e_dat;
    n       = mq[k].size();
    e_empty = (n == 0);
    e_full  = (n == dep[k]);
    e_rdy   = !e_full && !fl[k];
    bypass  = ft[k] && e_empty;
    if (bypass) begin
      e_vld = pv[k] && !fl[k];
      e_dat = pd[k];
    end else begin
      e_vld = !e_empty && !fl[k];
      e_dat = e_empty ? '0 : mq[k][0];
    end
    chk($sformatf("buf%0d_push_ready", k), 32'(prdy[k]), 32'(e_rdy));
    chk($sformatf("buf%0d_pop_valid", k), 32'(vld[k]), 32'(e_vld));
    chk($sformatf("buf%0d_usage", k), 32'(use_o[k]), n);
    chk($sformatf("buf%0d_full", k), 32'(fullo[k]), 32'(e_full));
    chk($sformatf("buf%0d_empty", k), 32'(emptyo[k]), 32'(e_empty));
    if (e_vld) chk($sformatf("buf%0d_pop_data", k), 32'(dat[k]), 32'(e_dat));
    if (fl[k]) begin
      mq[k].delete();
    end else begin
      push = pv[k] && e_rdy;
      pop  = e_vld && pr[k];
      if (!(bypass && pop)) begin
        if (pop) void'(mq[k].pop_front());
        if (push) mq[k].push_back(pd[k]);
      end
    end
  endtask

  task automatic check_pass();
    chk("pass_pop_valid", 32'(p_vld), 32'(p_pv && !p_fl));
    chk("pass_push_ready", 32'(p_rdy), 32'(p_pr && !p_fl));
    chk("pass_pop_data", 32'(p_dat), 32'(p_pd));
    chk("pass_usage", 32'(p_use), 0);
    chk("pass_full_empty", {30'd0, p_full, p_empty}, 32'h1);
  endtask

  task automatic cycle();
    #2;
    for (int k = 0; k < 3; k++) check_buf(k);
    check_pass();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pv = '0; pr = '0; fl = '0; pd = '0;
    p_pv = 1'b0; p_pr = 1'b0; p_fl = 1'b0; p_pd = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    p_pr = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_push_ready", k), 32'(prdy[k]), 1);
      chk($sformatf("rst%0d_pop_valid", k), 32'(vld[k]), 0);
      chk($sformatf("rst%0d_pop_data", k), 32'(dat[k]), 0);
      chk($sformatf("rst%0d_usage", k), 32'(use_o[k]), 0);
      chk($sformatf("rst%0d_flags", k), {30'd0, fullo[k], emptyo[k]}, 32'h1);
    end
    chk("rst_pass_ready", 32'(p_rdy), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill and drain on the two-entry buffer
    idle();
    pv[0] = 1'b1; pd[0] = 16'h000A; cycle();
    pd[0] = 16'h000B; cycle();
    pv[0] = 1'b0; cycle();
    chk("fill_full", 32'(fullo[0]), 1);
    pr[0] = 1'b1; cycle(); cycle(); cycle();
    chk("drain_empty", 32'(emptyo[0]), 1);

    // Wrap-around on the three-entry buffer with continuous pop
    idle();
    pr[1] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      pv[1] = 1'b1; pd[1] = DW'(i); cycle();
    end
    pv[1] = 1'b0; cycle(); cycle();

    // Fall-through: bypass when popped, store when not
    idle();
    pr[2] = 1'b1; pv[2] = 1'b1; pd[2] = 16'h0055; cycle();
    pv[2] = 1'b0; cycle();
    pr[2] = 1'b0; pv[2] = 1'b1; cycle();
    pv[2] = 1'b0; cycle();
    chk("ft_stored_usage", 32'(use_o[2]), 1);
    pr[2] = 1'b1; cycle();
    pr[2] = 1'b0; cycle();

    // Pass-through handshake and flush
    idle();
    p_pv = 1'b1; p_pd = 16'h1234; cycle();
    p_pr = 1'b1; cycle();
    p_fl = 1'b1; cycle();

    // Flush with two stored entries and a push offered during flush
    idle();
    pv[0] = 1'b1; pd[0] = 16'h0011; cycle();
    pd[0] = 16'h0022; cycle();
    fl[0] = 1'b1; pd[0] = 16'h0077; cycle();
    fl[0] = 1'b0; pv[0] = 1'b0; cycle();
    pr[0] = 1'b1; cycle();

    // Asynchronous reset between edges with one entry stored
    idle();
    pv[0] = 1'b1; pd[0] = 16'h0009; cycle();
    pv[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pop_valid", 32'(vld[0]), 0);
    chk("arst_usage", 32'(use_o[0]), 0);
    chk("arst_pop_data", 32'(dat[0]), 0);
    chk("arst_empty", 32'(emptyo[0]), 1);
    for (int k = 0; k < 3; k++) mq[k].delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pv[0] = 1'b1; pd[0] = 16'h0003; cycle();
    pv[0] = 1'b0; pr[0] = 1'b1; cycle();
    cycle();

    // Random traffic on every instance
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        pv[k] = 1'($urandom_range(0, 1));
        pr[k] = 1'($urandom_range(0, 1));
        fl[k] = ($urandom_range(0, 15) == 0);
        pd[k] = DW'($urandom);
      end
      p_pv = 1'($urandom_range(0, 1));
      p_pr = 1'($urandom_range(0, 1));
      p_fl = ($urandom_range(0, 7) == 0);
      p_pd = DW'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_ss_in_buf.md
# fpu_ss_in_buf

Input buffer of the FPU subsystem. It sits between the issue-interface acceptance logic and the subsystem controller. Each accepted offload request (decoded instruction, operands, id, metadata) is pushed as an opaque `DATA_WIDTH`-bit word. The controller pops the word once it has dispatched the instruction to FPnew, the memory interface, or the CSR path. The buffer decouples issue from dispatch so the core is not stalled by operand dependencies or a busy FPU.

## Interface
- `DATA_WIDTH`, default 64: width of one buffered entry.
- `DEPTH`, default 2: number of entries.
  - 0 selects pure combinational pass-through.
  - Any value ≥1 is legal; powers of two are not required.
- `FALL_THROUGH`, default 0: when 1, a push into an empty buffer is visible on the pop side in the same cycle.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `flush_i` input 1: synchronous clear of all entries.
- `push_valid_i` input 1: entry offered.
- `push_ready_o` output 1: entry can be accepted.
- `push_data_i` input `DATA_WIDTH`: entry payload.
- `pop_valid_o` output 1: head entry valid.
- `pop_ready_i` input 1: consumer takes head entry.
- `pop_data_o` output `DATA_WIDTH`: head entry payload.
- `usage_o` output `max(1,$clog2(DEPTH+1))`: number of stored entries.
- `full_o` output 1: `usage_o == DEPTH` (tied to 0 when `DEPTH==0`).
- `empty_o` output 1: `usage_o == 0`.

## Operation
- Push handshake: `push_valid_i & push_ready_o`. Pop handshake: `pop_valid_o & pop_ready_i`.
- Payload on either side is held stable by the producer while valid is high and ready is low. The buffer never drops an accepted entry except on flush.

**`DEPTH==0`:**
- `pop_valid_o = push_valid_i & ~flush_i`.
- `push_ready_o = pop_ready_i & ~flush_i`.
- `pop_data_o = push_data_i`.
- `usage_o=0`, `empty_o=1`, `full_o=0`.
- No state.

**`DEPTH≥1`:** circular storage `mem[DEPTH]` with write pointer `wr_ptr`, read pointer `rd_ptr` and counter `cnt`.
- Pointers increment and wrap from `DEPTH-1` to 0. There is no power-of-two aliasing.
- `push_ready_o = ~full_o & ~flush_i`.
  - Ready deliberately does not depend on `pop_ready_i`, so there is no combinational ready path through the buffer.
  - A full buffer accepts no push even when it is being popped that cycle.
- `pop_valid_o = ~empty_o & ~flush_i`.
- `pop_data_o = mem[rd_ptr]`.
- Push only: `mem[wr_ptr] <= push_data_i`, `wr_ptr++`, `cnt++`.
- Pop only: `rd_ptr++`, `cnt--`.
- Push and pop in the same cycle (non-empty, non-full): both pointers advance, `cnt` is unchanged.

**`FALL_THROUGH=1`, `DEPTH≥1`:**
- While `empty_o` is high:
  - `pop_valid_o = push_valid_i & ~flush_i`.
  - `pop_data_o = push_data_i`.
- If a pop handshake occurs in that cycle, the entry bypasses storage: no pointer or count change.
- If no pop occurs, the entry is written normally.
- When not empty, behaviour is identical to `FALL_THROUGH=0`.

**Flush:**
- While `flush_i` is high, `push_ready_o=0` and `pop_valid_o=0`, so no handshake can occur.
- At the next edge, `wr_ptr`, `rd_ptr` and `cnt` are reset to 0.
- Storage contents are not cleared.

**Reset (`rst_i` high, asynchronous, any time including mid-transfer):**
- Pointers, `cnt` and `mem` go to 0.
- Outputs take these values immediately:
  - `pop_valid_o=0`.
  - `push_ready_o=1` for `DEPTH≥1`, or `=pop_ready_i` for `DEPTH==0`.
  - `pop_data_o=0`.
  - `usage_o=0`, `empty_o=1`, `full_o=0`.
- With `FALL_THROUGH=1` during reset, the pass-through term still applies to `pop_valid_o` and `pop_data_o`. Consumers must ignore the pop side during reset.

## Timing
- Push-to-pop latency:
  - 1 cycle for `DEPTH≥1, FALL_THROUGH=0`: an entry pushed at edge N is `pop_valid_o` after edge N.
  - 0 cycles for `DEPTH==0`, or for `FALL_THROUGH=1` when empty.
- Throughput is one push and one pop per cycle, except that a full buffer sustains at most one entry per cycle alternating (pop, then push next cycle).
- `usage_o`, `full_o` and `empty_o` are registered-state-derived. They are updated one edge after the handshake and do not reflect same-cycle handshakes.
- Combinational paths:
  - `DEPTH==0`: `push_*` → `pop_*` and `pop_ready_i` → `push_ready_o`.
  - `FALL_THROUGH=1`: `push_valid_i`/`push_data_i` → `pop_valid_o`/`pop_data_o`.
  - `flush_i` → both ready and valid, in every configuration.

## Test plan
- **Fill and drain, no wrap** (`DEPTH=2`, `FALL_THROUGH=0`, `pop_ready_i=0`): push `0xA`, `0xB` on consecutive cycles → `usage_o=2`, `full_o=1`, `push_ready_o=0`. Then set `pop_ready_i=1` → pops `0xA` then `0xB`, ending with `empty_o=1`, `usage_o=0`.
- **Wrap-around** (`DEPTH=3`, `pop_ready_i=1`): push 7 entries `1..7` with simultaneous pop each cycle → output order `1..7`, `rd_ptr` wraps 2→0 twice, `usage_o` never exceeds 1.
- **Fall-through** (`DEPTH=2`, `FALL_THROUGH=1`, empty, `pop_ready_i=1`): push `0x55` → `pop_valid_o=1`, `pop_data_o=0x55` in the same cycle; next cycle `usage_o=0`. Repeat with `pop_ready_i=0` → `usage_o=1`, then `0x55` pops on the next cycle.
- **Pass-through** (`DEPTH=0`): `push_valid_i=1`, `pop_ready_i=0` → `push_ready_o=0`, `pop_valid_o=1`, `pop_data_o=push_data_i`. Raise `pop_ready_i` → handshake completes on both sides in the same cycle.
- **Flush with entries** (`DEPTH=2`, two entries stored, `push_valid_i=1` during flush): assert `flush_i` for one cycle → `pop_valid_o=0` and `push_ready_o=0` in that cycle, `usage_o=0` after the edge, and the pushed word is not stored.
- **Reset mid-operation** (`DEPTH=2`, one entry stored): assert `rst_i` asynchronously between edges → `pop_valid_o` falls immediately, `usage_o=0`, `pop_data_o=0`. After release, a push of `0x3` pops as `0x3` with no stale entry ahead of it.
